token_drawer: RTL
=================

Name: token_drawer

Overview:
Downstream drawing stage for the Connect-4 game controller. It accepts one "place token" request (column, row, player) per move and rasterises that board cell into the 160x120 VGA adapter framebuffer, one pixel per clock. It pulses draw_done when finished; this is the signal the controller waits on before switching player. After reset it first paints the empty board: blue frame with black holes.

Parameters:
CELL, 16, cell edge in pixels; must be a power of 2
MARGIN, 2, frame width inside each cell drawn in board colour
X0, 24, board left edge, pixel x
Y0, 12, board top edge, pixel y
COLS, 7, board columns
ROWS, 6, board rows; row 0 is the bottom row

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
req_valid  in  1  draw request; sampled only in IDLE
req_col  in  3  column 0..6
req_row  in  3  row 0..5, 0 = bottom
req_player  in  2  0 = empty, 1 = player 1, 2 = player 2, 3 = reserved
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  RGB colour
vga_plot  out  1  write enable to VGA adapter
busy  out  1  high in every state except IDLE
draw_done  out  1  one-cycle pulse when a request completes

Behaviour:
- States: CLEAR, IDLE, DRAW, DONE. All state and counters are registered.
- Reset: state goes to CLEAR; pixel counters = 0; draw_done = 0; request latches cleared.
- Reset has priority over everything. Reset mid-DRAW or mid-CLEAR abandons the operation, and CLEAR restarts at (0,0) on the cycle after reset deasserts.
- CLEAR:
  - Sweeps x 0..159 (inner loop), y 0..119; vga_plot = 1 every cycle; 19200 cycles total.
  - Colour: pixels outside the board rectangle [X0, X0+COLS*CELL) x [Y0, Y0+ROWS*CELL) are black 3'b000.
  - Inside the board, let dx = (x-X0) mod CELL and dy = (y-Y0) mod CELL. Pixels with dx,dy both in [MARGIN, CELL-1-MARGIN] are black (hole); all other board pixels are blue 3'b001.
  - After pixel (159,119), go to IDLE. No draw_done pulse after CLEAR.
- IDLE:
  - vga_plot = 0; busy = 0.
  - When req_valid = 1, latch col, row and player.
  - Valid request (col < COLS, row < ROWS): go to DRAW.
  - Invalid request: go directly to DONE with no pixels plotted.
  - req_valid in any other state is ignored (not queued).
- DRAW:
  - Cell origin: cx = X0 + col*CELL, cy = Y0 + (ROWS-1-row)*CELL.
  - Sweeps dx 0..CELL-1 (inner loop), dy 0..CELL-1; vga_x = cx+dx, vga_y = cy+dy, vga_plot = 1.
  - Colour: frame pixels (outside the MARGIN window) are blue. Window pixels are:
    - player 1: red 3'b100
    - player 2: yellow 3'b110
    - player 0 or 3: black
  - After CELL*CELL cycles, go to DONE.
- DONE: draw_done = 1 and vga_plot = 0 for exactly one cycle, then IDLE.
- Latency: a request accepted at cycle T plots pixels in cycles T+1..T+256 and pulses draw_done at T+257. An invalid request pulses draw_done at T+1.
- Outputs in CLEAR and DRAW are driven combinationally from the registered counters, so each pixel's x, y, colour and plot appear together in the same cycle.
- Arithmetic: x and y sums are computed at 9 bits and truncated. The default parameters guarantee x ≤ 159 and y ≤ 119, so no wrap occurs. Because CELL is a power of 2, dx and dy are the low log2(CELL) bits of the offsets.

Decomposition:
- Shared package connect4_pkg holds:
  - colour constants: COL_BLACK, COL_BLUE, COL_RED, COL_YELLOW
  - player codes P_EMPTY, P1, P2
  - board dimensions COLS, ROWS
  - screen size 160x120
  - state enum for this block
- One sub-module, xy_sweep: a 2-D raster counter with programmable x/y limits, a start input and a last-pixel flag. It is reused for both CLEAR (160x120) and DRAW (CELL x CELL).

Test Plan:
- Reset, then release: busy = 1 for exactly 19200 cycles with vga_plot = 1 throughout. Required pixels: (0,0) black, (24,12) blue, (26,14) black, (135,107) blue. Then busy = 0 and no draw_done pulse.
- Request col=0 row=0 player=1 accepted at T: first pixel at T+1 is (24,92) blue; pixel (26,94) red; last pixel (39,107) blue at T+256; draw_done = 1 only at T+257.
- Request col=6 row=5 player=2: pixels span x 120..135, y 12..27; (122,14) yellow; 256 plots total.
- Invalid request col=7 row=2 at T: no vga_plot at all; draw_done at T+1; busy back to 0 at T+2.
- req_valid held high during DRAW: only one draw_done pulse. A second request issued at T+258 (IDLE) is accepted normally.
- Reset asserted at the 100th DRAW pixel: no draw_done pulse. The cycle after reset deasserts, state is CLEAR with vga_x = 0, vga_y = 0, vga_plot = 1.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 controller datapath:
// colours, player codes, board and screen dimensions, drawer states.
package connect4_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLS     = 7;
    localparam int ROWS     = 6;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    localparam logic [1:0] P_EMPTY = 2'd0;
    localparam logic [1:0] P1      = 2'd1;
    localparam logic [1:0] P2      = 2'd2;

    typedef enum logic [1:0] {CLEAR, IDLE, DRAW, DONE} state_t;
endpackage

// File: rtl/xy_sweep.sv
// 2-D raster counter: x runs 0..x_last (inner), y runs 0..y_last (outer).
// last flags the final pixel; the next step wraps back to (0,0).
module xy_sweep (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] x_last,
    input  logic [6:0] y_last,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);
    assign last = (x == x_last) && (y == y_last);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x == x_last) begin
                x <= '0;
                y <= last ? 7'd0 : y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end
endmodule

// File: rtl/token_drawer.sv
// Rasterises Connect-4 board cells into a 160x120 VGA framebuffer, one pixel
// per clock; paints the empty board after reset and pulses draw_done per move.
module token_drawer #(
    parameter int CELL   = 16,
    parameter int MARGIN = 2,
    parameter int X0     = 24,
    parameter int Y0     = 12,
    parameter int COLS   = connect4_pkg::COLS,
    parameter int ROWS   = connect4_pkg::ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_col,
    input  logic [2:0] req_row,
    input  logic [1:0] req_player,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       draw_done
);
    import connect4_pkg::state_t;
    import connect4_pkg::CLEAR;
    import connect4_pkg::IDLE;
    import connect4_pkg::DRAW;
    import connect4_pkg::DONE;
    import connect4_pkg::SCREEN_W;
    import connect4_pkg::SCREEN_H;
    import connect4_pkg::COL_BLACK;
    import connect4_pkg::COL_BLUE;
    import connect4_pkg::COL_RED;
    import connect4_pkg::COL_YELLOW;
    import connect4_pkg::P1;
    import connect4_pkg::P2;

    localparam int         LOG_CELL   = $clog2(CELL);
    localparam logic [7:0] CLR_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CLR_Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [8:0] BX_LO      = 9'(X0);
    localparam logic [8:0] BX_HI      = 9'(X0 + COLS * CELL);
    localparam logic [8:0] BY_LO      = 9'(Y0);
    localparam logic [8:0] BY_HI      = 9'(Y0 + ROWS * CELL);

    state_t              state, next_state;
    logic [2:0]          col, row;
    logic [1:0]          player;
    logic                sweep_start, sweep_step, sweep_last;
    logic [7:0]          sx, x_last;
    logic [6:0]          sy, y_last;
    logic                req_ok, in_board;
    logic [8:0]          cx, cy;
    logic [LOG_CELL-1:0] ox, oy;

    // True when an in-cell offset lies inside the hole/token window.
    function automatic logic in_window(input logic [LOG_CELL-1:0] d);
        return (int'(d) >= MARGIN) && (int'(d) <= CELL - 1 - MARGIN);
    endfunction

    xy_sweep sweep (
        .clk    (clk),
        .reset  (reset),
        .start  (sweep_start),
        .step   (sweep_step),
        .x_last (x_last),
        .y_last (y_last),
        .x      (sx),
        .y      (sy),
        .last   (sweep_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            col    <= '0;
            row    <= '0;
            player <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                col    <= req_col;
                row    <= req_row;
                player <= req_player;
            end
        end
    end

    assign req_ok   = ({1'b0, req_col} < 4'(COLS)) && ({1'b0, req_row} < 4'(ROWS));
    // Row 0 is the bottom of the board, so screen y counts down from the top row.
    assign cx       = 9'(X0) + (9'(col) << LOG_CELL);
    assign cy       = 9'(Y0) + ((9'(ROWS - 1) - 9'(row)) << LOG_CELL);
    assign in_board = ({1'b0, sx} >= BX_LO) && ({1'b0, sx} < BX_HI) &&
                      ({2'b0, sy} >= BY_LO) && ({2'b0, sy} < BY_HI);

    always_comb begin
        next_state  = state;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;
        x_last      = 8'(CELL - 1);
        y_last      = 7'(CELL - 1);
        ox          = sx[LOG_CELL-1:0];
        oy          = sy[LOG_CELL-1:0];
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = COL_BLACK;
        vga_plot    = 1'b0;
        busy        = 1'b1;
        draw_done   = 1'b0;
        unique case (state)
            CLEAR: begin
                x_last     = CLR_X_LAST;
                y_last     = CLR_Y_LAST;
                sweep_step = 1'b1;
                ox         = LOG_CELL'(sx - 8'(X0));
                oy         = LOG_CELL'(sy - 7'(Y0));
                vga_x      = sx;
                vga_y      = sy;
                vga_plot   = 1'b1;
                if (in_board && !(in_window(ox) && in_window(oy)))
                    vga_colour = COL_BLUE;
                if (sweep_last)
                    next_state = IDLE;
            end
            IDLE: begin
                busy        = 1'b0;
                sweep_start = 1'b1;
                if (req_valid)
                    next_state = req_ok ? DRAW : DONE;
            end
            DRAW: begin
                sweep_step = 1'b1;
                vga_x      = 8'(cx + 9'(sx));
                vga_y      = 7'(cy + 9'(sy));
                vga_plot   = 1'b1;
                if (!(in_window(ox) && in_window(oy)))
                    vga_colour = COL_BLUE;
                else if (player == P1)
                    vga_colour = COL_RED;
                else if (player == P2)
                    vga_colour = COL_YELLOW;
                if (sweep_last)
                    next_state = DONE;
            end
            DONE: begin
                draw_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = CLEAR;
        endcase
    end
endmodule
